demux_1_n_stream: RTL and testbench

- Packet-aware 1-to-N stream demultiplexer; the inverse of the library's N-to-1 mux.
- Takes one valid/ready stream carrying data, last and a destination select, and steers whole packets to one of N output streams.
- The output is registered: 1 beat of storage, full throughput.
- Sits between a shared ingress stream and per-channel consumers.

---
 rtl/demux_stream_pkg.sv | 12 +
 rtl/stream_reg_slice.sv | 38 +++
 rtl/demux_1_n_stream.sv | 177 +++++++++++++++++
 tb/tb_demux_1_n_stream.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_stream_pkg.sv
// Shared types and constants for the packet-aware 1-to-N stream demultiplexer.
package demux_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int CNT_W = 16;

endpackage

// File: rtl/stream_reg_slice.sv
// Single-entry valid/ready holding register. It can take a new beat in the
// same cycle that it hands the held beat on, so it keeps full throughput.
module stream_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         hv_r;
  logic [W-1:0] hdata_r;

  assign in_ready  = ~hv_r | out_ready;
  assign out_valid = hv_r;
  assign out_data  = hdata_r;

  // Load on an accepted beat; otherwise empty when the consumer takes the held beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv_r    <= 1'b0;
      hdata_r <= '0;
    end else if (in_valid && in_ready) begin
      hv_r    <= 1'b1;
      hdata_r <= in_data;
    end else if (out_ready) begin
      hv_r    <= 1'b0;
    end else begin
      hv_r    <= hv_r;
    end
  end

endmodule

// File: rtl/demux_1_n_stream.sv
// Packet-aware 1-to-N stream demux: each packet's route is locked on its first beat.
// Optional per-output packet counters are enabled by DEMUX_1_N_STREAM_CNT_EN.
module demux_1_n_stream
  import demux_stream_pkg::*;
#(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(N_OUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [SEL_W-1:0]  in_sel,
  output logic [N_OUT-1:0]  out_valid,
  input  logic [N_OUT-1:0]  out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              drop_pulse
`ifdef DEMUX_1_N_STREAM_CNT_EN
  ,
  input  logic                   cnt_clr,
  output logic [N_OUT*CNT_W-1:0] pkt_cnt
`endif
);

  localparam int HOLD_W = DATA_W + 1 + SEL_W;
  localparam logic [SEL_W:0] N_OUT_LIM = (SEL_W + 1)'(N_OUT);

  state_t              state_r;
  logic [SEL_W-1:0]    route_r;
  logic                drop_pulse_r;

  logic                sel_legal_s;
  logic                load_en_s;
  logic [SEL_W-1:0]    load_sel_s;
  logic                accept_s;
  logic                slice_in_ready_s;
  logic                hold_valid_s;
  logic [HOLD_W-1:0]   hold_word_s;
  logic [DATA_W-1:0]   hdata_s;
  logic                hlast_s;
  logic [SEL_W-1:0]    hsel_s;
  logic                sel_ready_s;

  assign sel_legal_s = ({1'b0, in_sel} < N_OUT_LIM);
  assign accept_s    = in_valid & in_ready;
  assign {hdata_s, hlast_s, hsel_s} = hold_word_s;

  // Decide whether an incoming beat is stored and which route it carries
  always_comb begin
    load_en_s  = 1'b0;
    load_sel_s = route_r;
    case (state_r)
      IDLE: begin
        load_en_s  = sel_legal_s;
        load_sel_s = in_sel;
      end
      PKT: begin
        load_en_s  = 1'b1;
        load_sel_s = route_r;
      end
      DROP: begin
        load_en_s  = 1'b0;
        load_sel_s = route_r;
      end
      default: begin
        load_en_s  = 1'b0;
        load_sel_s = route_r;
      end
    endcase
  end

  // Decode the held route into per-output valid and pick that output's ready
  always_comb begin
    out_valid   = '0;
    sel_ready_s = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (hsel_s == SEL_W'(i)) begin
        out_valid[i] = hold_valid_s;
        sel_ready_s  = out_ready[i];
      end else begin
        out_valid[i] = 1'b0;
      end
    end
  end

  // Discarded packets never wait on an output
  always_comb begin
    if (state_r == DROP) begin
      in_ready = 1'b1;
    end else begin
      in_ready = slice_in_ready_s;
    end
  end

  assign out_data   = hdata_s;
  assign out_last   = hlast_s;
  assign drop_pulse = drop_pulse_r;

  stream_reg_slice #(
    .W (HOLD_W)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & load_en_s),
    .in_ready  (slice_in_ready_s),
    .in_data   ({in_data, in_last, load_sel_s}),
    .out_valid (hold_valid_s),
    .out_ready (sel_ready_s),
    .out_data  (hold_word_s)
  );

  // Packet FSM: lock the route on the first beat, release it on the last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      route_r      <= '0;
      drop_pulse_r <= 1'b0;
    end else begin
      drop_pulse_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            route_r <= in_sel;
            if (sel_legal_s) begin
              state_r <= in_last ? IDLE : PKT;
            end else begin
              drop_pulse_r <= 1'b1;
              state_r      <= in_last ? IDLE : DROP;
            end
          end
        end
        PKT, DROP: begin
          if (accept_s && in_last) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef DEMUX_1_N_STREAM_CNT_EN
  logic [CNT_W-1:0] cnt_r [N_OUT];

  // Count completed packets per output; a clear overrides a same-cycle count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OUT; i++) cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (cnt_clr) begin
          cnt_r[i] <= '0;
        end else if (out_valid[i] && out_ready[i] && hlast_s) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Flatten the counters onto the output bus
  always_comb begin
    pkt_cnt = '0;
    for (int i = 0; i < N_OUT; i++) begin
      pkt_cnt[i*CNT_W +: CNT_W] = cnt_r[i];
    end
  end
`endif

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Bench for demux_1_n_stream: a 4-output and a 3-output instance checked every
// cycle against a packet-level model, plus hand-computed directed expectations.
module tb_demux_1_n_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid [2];
  logic [7:0] in_data  [2];
  logic       in_last  [2];
  logic [1:0] in_sel   [2];
  logic [3:0] out_ready[2];
  logic       cnt_clr;

  logic       ir_a, ir_b, ol_a, ol_b, dp_a, dp_b;
  logic [3:0] ov_a;
  logic [2:0] ov_b;
  logic [7:0] od_a, od_b;
`ifdef DEMUX_1_N_STREAM_CNT_EN
  logic [63:0] pc_a;
  logic [47:0] pc_b;
`endif

  demux_1_n_stream #(.N_OUT(4), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(ir_a), .in_data(in_data[0]),
    .in_last(in_last[0]), .in_sel(in_sel[0]),
    .out_valid(ov_a), .out_ready(out_ready[0]), .out_data(od_a),
    .out_last(ol_a), .drop_pulse(dp_a)
`ifdef DEMUX_1_N_STREAM_CNT_EN
    , .cnt_clr(cnt_clr), .pkt_cnt(pc_a)
`endif
  );

  demux_1_n_stream #(.N_OUT(3), .DATA_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(ir_b), .in_data(in_data[1]),
    .in_last(in_last[1]), .in_sel(in_sel[1]),
    .out_valid(ov_b), .out_ready(out_ready[1][2:0]), .out_data(od_b),
    .out_last(ol_b), .drop_pulse(dp_b)
`ifdef DEMUX_1_N_STREAM_CNT_EN
    , .cnt_clr(cnt_clr), .pkt_cnt(pc_b)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] t=%0t: got 0x%0h expected 0x%0h", name, k, $time, act, exp);
    end
  endtask

  function automatic int n_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  // Packet-level model: one output slot, a "first beat" flag and a locked route
  bit       mv      [2];
  bit [7:0] md      [2];
  bit       ml      [2];
  int       mdest   [2];
  bit       in_pkt  [2];
  bit       dropping[2];
  int       route   [2];
  bit       mdrop   [2];
  int       mcnt    [2][4];

  function automatic bit exp_ready(input int k);
    return dropping[k] || !mv[k] || out_ready[k][mdest[k]];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit acc, load, hs;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mv[k] = 1'b0; md[k] = 8'h00; ml[k] = 1'b0; mdest[k] = 0;
        in_pkt[k] = 1'b0; dropping[k] = 1'b0; route[k] = 0; mdrop[k] = 1'b0;
        for (int o = 0; o < 4; o++) mcnt[k][o] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        hs   = mv[k] && out_ready[k][mdest[k]];
        acc  = in_valid[k] && exp_ready(k);
        load = 1'b0;
        mdrop[k] = 1'b0;
        if (cnt_clr) begin
          for (int o = 0; o < 4; o++) mcnt[k][o] = 0;
        end else if (hs && ml[k]) begin
          mcnt[k][mdest[k]] = (mcnt[k][mdest[k]] + 1) % 65536;
        end
        if (acc) begin
          if (!in_pkt[k] && !dropping[k]) begin
            route[k] = int'(in_sel[k]);
            if (int'(in_sel[k]) >= n_of(k)) begin
              mdrop[k]    = 1'b1;
              dropping[k] = !in_last[k];
            end else begin
              load      = 1'b1;
              in_pkt[k] = !in_last[k];
            end
          end else if (dropping[k]) begin
            if (in_last[k]) dropping[k] = 1'b0;
          end else begin
            load = 1'b1;
            if (in_last[k]) in_pkt[k] = 1'b0;
          end
        end
        if (load) begin
          mv[k] = 1'b1; md[k] = in_data[k]; ml[k] = in_last[k]; mdest[k] = route[k];
        end else if (hs) begin
          mv[k] = 1'b0;
        end
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge
  always @(negedge clk) begin
    logic [3:0] ov_k;
    for (int k = 0; k < 2; k++) begin
      ov_k = (k == 0) ? ov_a : {1'b0, ov_b};
      check("out_valid", k, 32'(ov_k), mv[k] ? (32'd1 << mdest[k]) : 32'd0);
      check("in_ready", k, 32'((k == 0) ? ir_a : ir_b), 32'(exp_ready(k)));
      check("drop_pulse", k, 32'((k == 0) ? dp_a : dp_b), 32'(mdrop[k]));
      if (mv[k]) begin
        check("out_data", k, 32'((k == 0) ? od_a : od_b), 32'(md[k]));
        check("out_last", k, 32'((k == 0) ? ol_a : ol_b), 32'(ml[k]));
      end
`ifdef DEMUX_1_N_STREAM_CNT_EN
      for (int o = 0; o < n_of(k); o++) begin
        check("pkt_cnt", k, (k == 0) ? 32'(pc_a[o*16 +: 16]) : 32'(pc_b[o*16 +: 16]), 32'(mcnt[k][o]));
      end
`endif
    end
  end

  task automatic drive(input int k, input bit v, input logic [7:0] d, input bit l, input int s);
    in_valid[k] = v;
    in_data[k]  = d;
    in_last[k]  = l;
    in_sel[k]   = 2'(s);
  endtask

  // Random traffic on one instance, holding each offered beat until accepted
  task automatic rand_run(input int k, input int cycles);
    bit pend = 1'b0;
    bit acc;
    for (int c = 0; c < cycles; c++) begin
      if (!pend) begin
        if ($urandom_range(0, 3) != 0) begin
          drive(k, 1'b1, 8'($urandom), $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)));
          pend = 1'b1;
        end else begin
          in_valid[k] = 1'b0;
        end
      end
      for (int o = 0; o < 4; o++) out_ready[k][o] = (o < n_of(k)) && ($urandom_range(0, 3) != 0);
      if (k == 0) cnt_clr = ($urandom_range(0, 63) == 0);
      #1;
      acc = in_valid[k] && ((k == 0) ? ir_a : ir_b);
      @(negedge clk);
      #1;
      if (acc) pend = 1'b0;
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = (k == 0) ? 4'hF : 4'h7;
    if (k == 0) cnt_clr = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) drive(k, 1'b0, 8'h00, 1'b0, 0);
    out_ready[0] = 4'hF;
    out_ready[1] = 4'h7;
    cnt_clr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 0, 32'(ov_a), 32'd0);
    check("rst_out_data", 0, 32'(od_a), 32'd0);
    check("rst_out_last", 0, 32'(ol_a), 32'd0);
    check("rst_drop", 0, 32'(dp_a), 32'd0);
    check("rst_in_ready", 0, 32'(ir_a), 32'd1);
    #1 rst_n = 1'b1;

    // Single-beat packets to every output, back to back
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 8'(8'h10 + i), 1'b1, i);
      @(negedge clk);
      check("t1_valid", 0, 32'(ov_a), 32'd1 << i);
      check("t1_data", 0, 32'(od_a), 32'h10 + 32'(i));
      check("t1_ready", 0, 32'(ir_a), 32'd1);
      #1;
    end
    drive(0, 1'b0, 8'h00, 1'b0, 0);
    @(negedge clk); #1;

    // Three-beat packet: later select values are ignored
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 8'(8'hA0 + i), i == 2, (i == 0) ? 2 : (i - 1));
      @(negedge clk);
      check("t2_valid", 0, 32'(ov_a), 32'h4);
      check("t2_data", 0, 32'(od_a), 32'hA0 + 32'(i));
      check("t2_last", 0, 32'(ol_a), (i == 2) ? 32'd1 : 32'd0);
      #1;
    end
    drive(0, 1'b0, 8'h00, 1'b0, 0);
    @(negedge clk); #1;

    // Backpressure on output 1 for five cycles mid-packet
    drive(0, 1'b1, 8'hB0, 1'b0, 1);
    @(negedge clk);
    check("t3_first", 0, 32'(od_a), 32'hB0);
    #1;
    drive(0, 1'b1, 8'hB1, 1'b0, 0);
    out_ready[0] = 4'b1101;
    repeat (5) begin
      @(negedge clk);
      check("t3_stall_ready", 0, 32'(ir_a), 32'd0);
      check("t3_stall_data", 0, 32'(od_a), 32'hB0);
      check("t3_stall_valid", 0, 32'(ov_a), 32'h2);
      #1;
    end
    out_ready[0] = 4'hF;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("t3_resume_data", 0, 32'(od_a), 32'hB0 + 32'(i));
      check("t3_resume_valid", 0, 32'(ov_a), 32'h2);
      #1;
      if (i < 3) drive(0, 1'b1, 8'(8'hB1 + i), i == 2, 3);
      else drive(0, 1'b0, 8'h00, 1'b0, 0);
    end
    @(negedge clk); #1;

    // Illegal select on the 3-output instance: whole packet dropped
    drive(1, 1'b1, 8'hE0, 1'b0, 3);
    @(negedge clk);
    check("t4_drop_valid", 1, 32'(ov_b), 32'd0);
    check("t4_drop_pulse", 1, 32'(dp_b), 32'd1);
    #1;
    drive(1, 1'b1, 8'hE1, 1'b1, 0);
    @(negedge clk);
    check("t4_drop_valid2", 1, 32'(ov_b), 32'd0);
    check("t4_drop_pulse2", 1, 32'(dp_b), 32'd0);
    #1;
    drive(1, 1'b1, 8'h55, 1'b1, 0);
    @(negedge clk);
    check("t4_next_valid", 1, 32'(ov_b), 32'h1);
    check("t4_next_data", 1, 32'(od_b), 32'h55);
    #1;
    drive(1, 1'b0, 8'h00, 1'b0, 0);
    @(negedge clk); #1;

    // Asynchronous reset after the first beat of a packet
    drive(0, 1'b1, 8'hC0, 1'b0, 3);
    @(negedge clk);
    check("t5_pre_valid", 0, 32'(ov_a), 32'h8);
    #1;
    drive(0, 1'b0, 8'h00, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 0, 32'(ov_a), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    drive(0, 1'b1, 8'hC1, 1'b1, 1);
    @(negedge clk);
    check("t5_new_valid", 0, 32'(ov_a), 32'h2);
    check("t5_new_data", 0, 32'(od_a), 32'hC1);
    #1;
    drive(0, 1'b0, 8'h00, 1'b0, 0);
    @(negedge clk); #1;

    fork
      rand_run(0, 3000);
      rand_run(1, 3000);
    join
    repeat (3) @(negedge clk);
    #1;

`ifdef DEMUX_1_N_STREAM_CNT_EN
    cnt_clr = 1'b1;
    @(negedge clk); #1;
    cnt_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 8'(i), 1'b1, (i < 3) ? 0 : 3);
      @(negedge clk); #1;
    end
    drive(0, 1'b0, 8'h00, 1'b0, 0);
    repeat (2) @(negedge clk);
    check("cnt_out0", 0, 32'(pc_a[15:0]), 32'd3);
    check("cnt_out3", 0, 32'(pc_a[63:48]), 32'd1);
    #1 cnt_clr = 1'b1;
    @(negedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check("cnt_clear", 0, 32'(pc_a), 32'd0);
    #1;
    for (int i = 0; i < 65535; i++) begin
      drive(1, 1'b1, 8'(i), 1'b1, 2);
      @(negedge clk); #1;
    end
    drive(1, 1'b0, 8'h00, 1'b0, 0);
    repeat (2) @(negedge clk);
    check("cnt_full", 1, 32'(pc_b[47:32]), 32'hFFFF);
    #1;
    drive(1, 1'b1, 8'h77, 1'b1, 2);
    @(negedge clk); #1;
    drive(1, 1'b0, 8'h00, 1'b0, 0);
    repeat (2) @(negedge clk);
    check("cnt_wrap", 1, 32'(pc_b[47:32]), 32'd0);
    #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
